// File: rtl/mux_arb_rr_if.sv
// mux_arb_rr_if: stream bundle between N producers, the arbitrated mux and one sink.
interface mux_arb_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N*W-1:0]         in_data;
  logic [N-1:0]           in_valid;
  logic [N-1:0]           in_ready;
  logic [W-1:0]           out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(N)-1:0]   out_sel;
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_arb_rr.sv
// mux_arb_rr: N-input arbitrated mux (round-robin or fixed priority) with a registered valid/ready output.
module mux_arb_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  mux_arb_rr_if.slave  bus
);
  logic [SELW-1:0] ptr, g;
  logic            found, load;
  int              j;
  // Search starts at ptr (round-robin) or 0 (fixed priority); first valid wins.
  always_comb begin
    found = 1'b0;
    g = '0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (mode ? 0 : int'(ptr)) + k;
      j = (j >= N) ? j - N : j;
      if (!found && bus.in_valid[j]) begin
        found = 1'b1;
        g = SELW'(j);
      end
    end
    load = found && rst_n && (!bus.out_valid || bus.out_ready);
    bus.in_ready = load ? N'(1) << g : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      bus.out_data <= '0;
      bus.out_sel <= '0;
      bus.out_valid <= 1'b0;
    end else if (load) begin
      bus.out_data <= bus.in_data[g*W +: W];
      bus.out_sel <= g;
      bus.out_valid <= 1'b1;
      ptr <= (g == SELW'(N-1)) ? '0 : g + SELW'(1);
    end else if (bus.out_ready)
      bus.out_valid <= 1'b0;
endmodule

// File: tb/tb_mux_arb_rr.sv
// tb_mux_arb_rr: directed vectors with hand-computed expectations for mux_arb_rr (N=4, W=8).
module tb_mux_arb_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  int   checks = 0;
  int   errors = 0;
  mux_arb_rr_if #(.N(4), .W(8)) bus ();
  mux_arb_rr #(.N(4), .W(8)) dut (.clk(clk), .rst_n(rst_n), .mode(mode), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic out_is(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_sel"}, 32'(bus.out_sel), 32'(s));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
  endtask
  initial begin
    logic [1:0] rr_sel [6];
    logic [7:0] rr_dat [6];
    rr_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rr_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
    bus.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.in_valid = 4'h0;
    bus.out_ready = 1'b1;
    // reset and idle
    #2;
    out_is("rst", 1'b0, 2'd0, 8'h00);
    bus.in_valid = 4'hF;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      out_is("idle", 1'b0, 2'd0, 8'h00);
      chk("idle_in_ready", 32'(bus.in_ready), 32'h0);
    end
    // round-robin fairness
    bus.in_valid = 4'hF;
    #1;
    chk("rr_ready0", 32'(bus.in_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      out_is("rr", 1'b1, rr_sel[i], rr_dat[i]);
    end
    // round-robin skip with wrap (ptr=2)
    bus.in_valid = 4'b0011;
    #1;
    chk("skip_ready", 32'(bus.in_ready), 32'h1);
    tick();
    out_is("skip0", 1'b1, 2'd0, 8'hA0);
    tick();
    out_is("skip1", 1'b1, 2'd1, 8'hA1);
    // fixed priority
    mode = 1'b1;
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_ready", 32'(bus.in_ready), 32'h2);
      tick();
      out_is("fp", 1'b1, 2'd1, 8'hA1);
    end
    bus.in_valid = 4'b1000;
    tick();
    out_is("fp_ch3", 1'b1, 2'd3, 8'hA3);
    // backpressure
    bus.in_data[23:16] = 8'h5C;
    bus.in_valid = 4'b0100;
    tick();
    out_is("bp_load", 1'b1, 2'd2, 8'h5C);
    mode = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(bus.in_ready), 32'h0);
      tick();
      out_is("bp_hold", 1'b1, 2'd2, 8'h5C);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'h8);
    tick();
    out_is("bp_next", 1'b1, 2'd3, 8'hA3);
    // drain
    bus.in_valid = 4'h0;
    tick();
    out_is("drain", 1'b0, 2'd3, 8'hA3);
    tick();
    out_is("drain_idle", 1'b0, 2'd3, 8'hA3);
    // asynchronous reset with a held word, then restart from ptr=0
    bus.in_valid = 4'b0100;
    tick();
    out_is("pre_rst", 1'b1, 2'd2, 8'h5C);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    out_is("async_rst", 1'b0, 2'd0, 8'h00);
    chk("async_rst_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
    tick();
    out_is("post_rst", 1'b1, 2'd0, 8'hA0);
    tick();
    out_is("post_rst2", 1'b1, 2'd1, 8'hA1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arb_rr.md
# mux_arb_rr

Parametrised N-input, W-bit arbitrated multiplexer with a registered output and a valid/ready handshake on every port. It supersedes the fixed 4:1 conditional mux for datapaths where several producers contend for one consumer. Selection is made by an internal arbiter, either round-robin or fixed-priority, instead of by external select lines. It sits between N stream producers and a single downstream stream sink.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: data width per channel, at least 1.
- SELW, default $clog2(N): width of the grant index. Derived; do not override.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Deassertion is synchronous to clk at system level.
- mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel request/valid.
- in_ready  output  N  per-channel accept. Combinational, at most one bit set (one-hot or zero).
- out_data  output  W  registered data of the last accepted word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  sink accepts the word when out_valid is also high.
- out_sel  output  SELW  channel index the held word came from.

## Operation
- Output stage: one register holding out_data, out_sel and out_valid.
- can_load = !out_valid || out_ready.
- Arbitration runs combinationally every cycle over in_valid.
  - mode=0: search starts at pointer ptr and goes upward with wrap-around (ptr, ptr+1, …, N-1, 0, …). The first asserted in_valid wins.
  - mode=1: the lowest asserted index wins; ptr is ignored.
- in_ready[g] = can_load && in_valid[g] for the winner g. All other in_ready bits are 0. in_ready is all-zero when no in_valid is set or can_load=0.
- Transfer on a channel = in_valid[i] && in_ready[i] at a rising edge. On transfer of channel g:
  - out_data ← in_data[g]
  - out_sel ← g
  - out_valid ← 1
  - ptr ← (g == N-1) ? 0 : g+1. ptr updates in both modes.
- Drain without load: out_valid && out_ready with no transfer → out_valid ← 0. out_data and out_sel hold their values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and out_valid stays 1. This is full throughput, one word per cycle.
- Stall: out_valid && !out_ready → no input is accepted. out_* hold. ptr holds.
- A producer must hold in_data and in_valid until accepted. The block never drops or duplicates a word.
- Changing mode takes effect in the same cycle's arbitration. No state is flushed.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is all-zero while rst_n is low.
- Reset asserted mid-transfer: the held word is discarded and nothing is accepted. After release, arbitration restarts from ptr=0.
- Latency: a word accepted at edge k is visible on out_data/out_valid immediately after edge k. That is 1 cycle of input-to-output latency.
- Throughput: 1 word per cycle while out_ready=1 and any in_valid=1.
- Combinational paths:
  - in_valid, mode, out_ready → in_ready.
  - There is no combinational path from in_data to any output.
- Fairness in mode=0: with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… Each channel waits at most N-1 grants.

## Test plan
- Reset and idle: hold rst_n=0, then release with in_valid=0. Required: out_valid=0, out_data=0, out_sel=0 and in_ready=0 on every cycle. Then assert rst_n=0 asynchronously between edges while out_valid=1; out_valid must fall immediately.
- Round-robin fairness, N=4, W=8, mode=0, out_ready=1: in_valid=4'b1111 with data 8'hA0..8'hA3. Required out_sel sequence 0,1,2,3,0,1 and out_data A0,A1,A2,A3,A0,A1, one per cycle.
- Round-robin skip: mode=0, ptr=2 after a grant to channel 1, in_valid=4'b0011. Required: the next grant is channel 0 (wrap), then channel 1.
- Fixed priority: mode=1, in_valid=4'b1010 held for 3 cycles. Required: out_sel=1 every cycle and in_ready=4'b0010. Channel 3 is starved until in_valid[1]=0, after which out_sel=3.
- Backpressure: load channel 2 with data 8'h5C, then out_ready=0 for 3 cycles with in_valid=4'b1111. Required: out_data=8'h5C and out_sel=2 held, in_ready=0, ptr unchanged. On out_ready=1 the next grant is channel 3 and the old word is replaced in the same cycle.
- Drain: a single word is loaded, then in_valid=0 and out_ready=1. Required: out_valid=0 one edge later while out_data and out_sel retain their last values.
